// File: rtl/fetch_decode_queue.sv
// ============================================================================
// Module   : fetch_decode_queue
// Brief    : Fetch-to-decode instruction buffer carrying branch-prediction metadata.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmm_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int HLEN = 8;
endpackage

module fetch_decode_queue
  import mmm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [ILEN-1:0]          instruction_i,
  input  logic [XLEN-1:0]          pred_pc_i,
  input  logic [HLEN-1:0]          pred_index_i,
  input  logic [XLEN-1:0]          pred_target_i,
  input  logic                     pred_taken_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [ILEN-1:0]          instruction_o,
  output logic [XLEN-1:0]          pred_pc_o,
  output logic [HLEN-1:0]          pred_index_o,
  output logic [XLEN-1:0]          pred_target_o,
  output logic                     pred_taken_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [ILEN-1:0]    r_instr  [DEPTH];
  logic [XLEN-1:0]    r_pc     [DEPTH];
  logic [HLEN-1:0]    r_index  [DEPTH];
  logic [XLEN-1:0]    r_target [DEPTH];
  logic               r_taken  [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Occupancy alone decides full/empty, so pointer wrap needs no extra bit.
  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  assign issue_ready_o = ~w_full & ~flush_i & ~rst_i;
  assign dec_valid_o   = ~w_empty & ~flush_i & ~rst_i;

  assign w_push = issue_valid_i & issue_ready_o;
  assign w_pop  = dec_valid_o & dec_ready_i;

  assign instruction_o = r_instr[r_rd_ptr];
  assign pred_pc_o     = r_pc[r_rd_ptr];
  assign pred_index_o  = r_index[r_rd_ptr];
  assign pred_target_o = r_target[r_rd_ptr];
  assign pred_taken_o  = r_taken[r_rd_ptr];
  assign count_o       = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i]  <= '0;
        r_pc[i]     <= '0;
        r_index[i]  <= '0;
        r_target[i] <= '0;
        r_taken[i]  <= 1'b0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr]  <= instruction_i;
        r_pc[r_wr_ptr]     <= pred_pc_i;
        r_index[r_wr_ptr]  <= pred_index_i;
        r_target[r_wr_ptr] <= pred_target_i;
        r_taken[r_wr_ptr]  <= pred_taken_i;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
// ============================================================================
// Module   : tb_fetch_decode_queue
// Brief    : Directed vector bench for fetch_decode_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_decode_queue;
  import mmm_pkg::*;

  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [ILEN-1:0] instruction_i;
  logic [XLEN-1:0] pred_pc_i;
  logic [HLEN-1:0] pred_index_i;
  logic [XLEN-1:0] pred_target_i;
  logic            pred_taken_i;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [ILEN-1:0] instruction_o;
  logic [XLEN-1:0] pred_pc_o;
  logic [HLEN-1:0] pred_index_o;
  logic [XLEN-1:0] pred_target_o;
  logic            pred_taken_o;
  logic [2:0]      count_o;

  int n_checks = 0;
  int n_errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .instruction_i (instruction_i),
    .pred_pc_i     (pred_pc_i),
    .pred_index_i  (pred_index_i),
    .pred_target_i (pred_target_i),
    .pred_taken_i  (pred_taken_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .instruction_o (instruction_o),
    .pred_pc_o     (pred_pc_o),
    .pred_index_o  (pred_index_o),
    .pred_target_o (pred_target_o),
    .pred_taken_o  (pred_taken_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Metadata is derived from the PC so one number identifies a whole entry.
  function automatic logic [ILEN-1:0] f_instr(input logic [XLEN-1:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction
  function automatic logic [HLEN-1:0] f_index(input logic [XLEN-1:0] pc);
    return pc[HLEN+1:2];
  endfunction
  function automatic logic [XLEN-1:0] f_target(input logic [XLEN-1:0] pc);
    return pc + 32'h40;
  endfunction
  function automatic logic f_taken(input logic [XLEN-1:0] pc);
    return pc[2];
  endfunction

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic        dr;
    logic [31:0] pc;
    logic        e_ir;
    logic        e_dv;
    logic [2:0]  e_cnt;
    int          mode;   // 0: no data check, 1: head is entry e_pc, 2: data all zero
    logic [31:0] e_pc;
  } vec_t;

  localparam int N_VEC = 28;
  vec_t tbl [N_VEC];

  function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                              input logic dr, input logic [31:0] pc, input logic e_ir,
                              input logic e_dv, input logic [2:0] e_cnt, input int mode,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.dr = dr; v.pc = pc;
    v.e_ir = e_ir; v.e_dv = e_dv; v.e_cnt = e_cnt; v.mode = mode; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic rst, input logic flush, input logic iv,
                       input logic dr, input logic [31:0] pc);
    rst_i         = rst;
    flush_i       = flush;
    issue_valid_i = iv;
    dec_ready_i   = dr;
    pred_pc_i     = pc;
    instruction_i = f_instr(pc);
    pred_index_i  = f_index(pc);
    pred_target_i = f_target(pc);
    pred_taken_i  = f_taken(pc);
  endtask

  task automatic check_outputs(input string tag, input logic e_ir, input logic e_dv,
                               input logic [2:0] e_cnt, input int mode,
                               input logic [31:0] e_pc);
    chk({tag, " issue_ready"}, 64'(issue_ready_o), 64'(e_ir));
    chk({tag, " dec_valid"},   64'(dec_valid_o),   64'(e_dv));
    chk({tag, " count"},       64'(count_o),       64'(e_cnt));
    if (mode == 1) begin
      chk({tag, " pc"},     64'(pred_pc_o),     64'(e_pc));
      chk({tag, " instr"},  64'(instruction_o), 64'(f_instr(e_pc)));
      chk({tag, " index"},  64'(pred_index_o),  64'(f_index(e_pc)));
      chk({tag, " target"}, 64'(pred_target_o), 64'(f_target(e_pc)));
      chk({tag, " taken"},  64'(pred_taken_o),  64'(f_taken(e_pc)));
    end else if (mode == 2) begin
      chk({tag, " zero_data"},
          64'({instruction_o, pred_pc_o} | 64'(pred_index_o) | 64'(pred_target_o)
              | 64'(pred_taken_o)), 64'd0);
    end
  endtask

  initial begin
    //            rst flush iv dr  pc        ir dv cnt mode e_pc
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 1, 0, 32'h100, 1, 0, 0, 2, 32'h0);
    tbl[2]  = mk(0, 0, 1, 0, 32'h104, 1, 1, 1, 1, 32'h100);
    tbl[3]  = mk(0, 0, 1, 0, 32'h108, 1, 1, 2, 1, 32'h100);
    tbl[4]  = mk(0, 0, 1, 0, 32'h10C, 1, 1, 3, 1, 32'h100);
    tbl[5]  = mk(0, 0, 1, 0, 32'h110, 0, 1, 4, 1, 32'h100);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,   0, 1, 4, 1, 32'h100);
    tbl[7]  = mk(0, 0, 0, 1, 32'h0,   0, 1, 4, 1, 32'h100);
    tbl[8]  = mk(0, 0, 0, 1, 32'h0,   1, 1, 3, 1, 32'h104);
    tbl[9]  = mk(0, 0, 0, 1, 32'h0,   1, 1, 2, 1, 32'h108);
    tbl[10] = mk(0, 0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h10C);
    tbl[11] = mk(0, 0, 0, 1, 32'h0,   1, 0, 0, 0, 32'h0);
    tbl[12] = mk(0, 0, 1, 0, 32'h400, 1, 0, 0, 0, 32'h0);
    tbl[13] = mk(0, 0, 1, 0, 32'h404, 1, 1, 1, 1, 32'h400);
    tbl[14] = mk(0, 0, 1, 0, 32'h408, 1, 1, 2, 1, 32'h400);
    tbl[15] = mk(0, 0, 1, 0, 32'h40C, 1, 1, 3, 1, 32'h400);
    tbl[16] = mk(0, 0, 1, 1, 32'h410, 0, 1, 4, 1, 32'h400);
    tbl[17] = mk(0, 0, 1, 1, 32'h410, 1, 1, 3, 1, 32'h404);
    tbl[18] = mk(0, 0, 1, 1, 32'h414, 1, 1, 3, 1, 32'h408);
    tbl[19] = mk(0, 1, 1, 1, 32'h418, 0, 0, 3, 0, 32'h0);
    tbl[20] = mk(0, 0, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0);
    tbl[21] = mk(0, 0, 1, 0, 32'h500, 1, 0, 0, 0, 32'h0);
    tbl[22] = mk(0, 0, 1, 0, 32'h504, 1, 1, 1, 1, 32'h500);
    tbl[23] = mk(1, 0, 0, 1, 32'h0,   0, 0, 2, 1, 32'h500);
    tbl[24] = mk(0, 0, 1, 0, 32'h300, 1, 0, 0, 2, 32'h0);
    tbl[25] = mk(0, 0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h300);
    tbl[26] = mk(0, 0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h300);
    tbl[27] = mk(0, 0, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0);

    drive(1, 0, 0, 0, 32'h0);
    repeat (2) @(negedge clk_i);

    // One row per cycle: inputs set after the falling edge, outputs sampled 1ns later.
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk_i);
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].dr, tbl[i].pc);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_dv,
                    tbl[i].e_cnt, tbl[i].mode, tbl[i].e_pc);
    end

    // Streaming through the empty queue: ten entries, pointers wrap repeatedly.
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk_i);
      if (k < 10) drive(0, 0, 1, 1, 32'h200 + 32'(4 * k));
      else        drive(0, 0, 0, 1, 32'h0);
      #1;
      if (k == 0 || k == 11)
        check_outputs($sformatf("stream%0d", k), 1'b1, 1'b0, 3'd0, 0, 32'h0);
      else
        check_outputs($sformatf("stream%0d", k), 1'b1, 1'b1, 3'd1, 1,
                      32'h200 + 32'(4 * (k - 1)));
    end

    @(negedge clk_i);
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check_outputs("idle_end", 1'b1, 1'b0, 3'd0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
